karatsuba_pipe: RTL and testbench

- Parametrised, 3-stage pipelined Karatsuba multiplier; successor to the fixed-width 32-bit combinational Karatsuba unit.
- Unsigned N×N → 2N product, split into N/2 halves, three sub-products recombined.
- Per-transaction selectable exact or approximate (low-bit operand truncation) mode.
- valid/ready handshakes on input and output; sits between operand source and accumulator datapath.

---
 rtl/karatsuba_pipe.sv | 118 +++++++++++
 tb/tb_karatsuba_pipe.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/karatsuba_pipe.sv
`default_nettype none
// ============================================================================
// Module      : karatsuba_pipe
// Description : 3-stage pipelined N x N -> 2N Karatsuba multiplier with
//               valid/ready handshakes and per-beat approximate (truncated)
//               mode. Optional perf counters: define KARATSUBA_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module karatsuba_pipe #(
    parameter int N = 32,
    parameter int T = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_a,
    input  logic [N-1:0]   in_b,
    input  logic           in_approx,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] out_p,
    output logic           out_approx
`ifdef KARATSUBA_PERF_CNT_EN
    ,
    output logic [31:0]    perf_total,
    output logic [31:0]    perf_approx
`endif
);

    localparam int K = N / 2;
    localparam logic [N-1:0] c_trunc_mask = ~((N'(1) << T) - N'(1));

    generate
        if ((N % 2) != 0 || N < 8 || T < 0 || T > N / 2) begin : g_bad_params
            $error("karatsuba_pipe: N must be even and >= 8, and 0 <= T <= N/2");
        end
    endgenerate

    logic           w_stall;
    logic [N-1:0]   w_a;
    logic [N-1:0]   w_b;

    logic           r1_valid;
    logic           r1_approx;
    logic [K-1:0]   r1_ah, r1_al, r1_bh, r1_bl;
    logic [K:0]     r1_s1, r1_s2;

    logic           r2_valid;
    logic           r2_approx;
    logic [2*K-1:0] r2_m1, r2_m2;
    logic [2*K+1:0] r2_m3;

    logic [2*K+1:0] w_m6;
    logic [2*N-1:0] w_p;

    assign w_stall  = out_valid & ~out_ready;
    assign in_ready = ~w_stall;

    assign w_a = in_approx ? (in_a & c_trunc_mask) : in_a;
    assign w_b = in_approx ? (in_b & c_trunc_mask) : in_b;

    // Middle term is non-negative by construction, so plain modular subtraction is exact.
    assign w_m6 = r2_m3 - (2*K+2)'(r2_m1) - (2*K+2)'(r2_m2);
    assign w_p  = {r2_m1, {N{1'b0}}} + ((2*N)'(w_m6) << K) + (2*N)'(r2_m2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid   <= 1'b0;
            r2_valid   <= 1'b0;
            out_valid  <= 1'b0;
            out_p      <= '0;
            out_approx <= 1'b0;
        end else if (!w_stall) begin
            r1_valid   <= in_valid;
            r2_valid   <= r1_valid;
            out_valid  <= r2_valid;
            out_p      <= w_p;
            out_approx <= r2_approx;
        end
    end

    // Datapath registers carry no reset; they are qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (!w_stall) begin
            r1_ah     <= w_a[N-1:K];
            r1_al     <= w_a[K-1:0];
            r1_bh     <= w_b[N-1:K];
            r1_bl     <= w_b[K-1:0];
            r1_s1     <= {1'b0, w_a[N-1:K]} + {1'b0, w_a[K-1:0]};
            r1_s2     <= {1'b0, w_b[N-1:K]} + {1'b0, w_b[K-1:0]};
            r1_approx <= in_approx;

            r2_m1     <= (2*K)'(r1_ah) * (2*K)'(r1_bh);
            r2_m2     <= (2*K)'(r1_al) * (2*K)'(r1_bl);
            r2_m3     <= (2*K+2)'(r1_s1) * (2*K+2)'(r1_s2);
            r2_approx <= r1_approx;
        end
    end

`ifdef KARATSUBA_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_total  <= '0;
            perf_approx <= '0;
        end else if (out_valid && out_ready) begin
            if (perf_total != 32'hFFFF_FFFF) begin
                perf_total <= perf_total + 32'd1;
            end
            if (out_approx && perf_approx != 32'hFFFF_FFFF) begin
                perf_approx <= perf_approx + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_karatsuba_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_karatsuba_pipe
// Description : Self-checking bench for karatsuba_pipe (N=32, T=8): vector
//               table, scoreboard queue, latency/stream/stall/reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_karatsuba_pipe;

    localparam int N = 32;
    localparam int T = 8;
    localparam logic [31:0] c_mask = 32'hFFFF_FF00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        in_approx = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_p;
    logic        out_approx;
`ifdef KARATSUBA_PERF_CNT_EN
    logic [31:0] perf_total;
    logic [31:0] perf_approx;
`endif

    always #5 clk = ~clk;

    karatsuba_pipe #(.N(N), .T(T)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_approx  (in_approx),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_p      (out_p),
        .out_approx (out_approx)
`ifdef KARATSUBA_PERF_CNT_EN
        ,
        .perf_total (perf_total),
        .perf_approx(perf_approx)
`endif
    );

    typedef struct packed {
        logic        ap;
        logic [63:0] p;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ap;
        logic [63:0] p;
    } vec_t;

    exp_t sbq[$];
    exp_t tb_exp;
    int   n_vec = 0;
    int   n_err = 0;
    int   run = 0;
    int   maxrun = 0;
    int   n_hs = 0;
    int   n_hs_ap = 0;
    logic rand_bp = 1'b0;
    logic prev_stall = 1'b0;
    logic prev_rst = 1'b1;
    logic [63:0] prev_p = '0;

    task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic ap);
        logic [31:0] ma, mb;
        ma = ap ? (a & c_mask) : a;
        mb = ap ? (b & c_mask) : b;
        return 64'(ma) * 64'(mb);
    endfunction

    // Scoreboard monitor: samples mid-cycle, the handshakes it sees complete at the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sbq.delete();
            run     = 0;
            n_hs    = 0;
            n_hs_ap = 0;
        end else begin
            if (prev_stall && !prev_rst) begin
                check64("stall_hold_valid", 64'(out_valid), 64'd1);
                check64("stall_hold_p", out_p, prev_p);
            end
            if (out_valid && out_ready) begin
                n_hs++;
                if (out_approx) n_hs_ap++;
                if (sbq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_out: got %h, expected no result", out_p);
                end else begin
                    e = sbq.pop_front();
                    check64("out_p", out_p, e.p);
                    check64("out_approx", 64'(out_approx), 64'(e.ap));
                end
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
            if (in_valid && in_ready) sbq.push_back(tb_exp);
        end
        prev_stall = out_valid && !out_ready;
        prev_p     = out_p;
        prev_rst   = rst;
    end

    always @(posedge clk) begin
        #1;
        if (rand_bp) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic ap, input logic [63:0] e);
        logic acc;
        acc       = 1'b0;
        in_a      = a;
        in_b      = b;
        in_approx = ap;
        tb_exp    = '{ap: ap, p: e};
        in_valid  = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got in_ready=0, expected acceptance");
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && sbq.size() != 0; i++) @(posedge clk);
        if (sbq.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sbq.size());
        end
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[10];

    initial begin
        tbl[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
        tbl[1] = '{32'h0000_01FF, 32'h0000_01FF, 1'b1, 64'h0000_0000_0001_0000};
        tbl[2] = '{32'h0000_01FF, 32'h0000_01FF, 1'b0, 64'h0000_0000_0003_FC01};
        tbl[3] = '{32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000};
        tbl[4] = '{32'h0000_FFFF, 32'hFFFF_0000, 1'b0, 64'h0000_FFFE_0001_0000};
        tbl[5] = '{32'h0000_00FF, 32'h0000_00FF, 1'b1, 64'h0000_0000_0000_0000};
        tbl[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FE00_0001_0000};
        tbl[7] = '{32'h0000_0000, 32'h1234_5678, 1'b0, 64'h0000_0000_0000_0000};
        tbl[8] = '{32'h8000_0000, 32'h0000_0002, 1'b0, 64'h0000_0001_0000_0000};
        tbl[9] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 64'h0000_0000_FFFF_FFFF};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check64("reset_out_valid", 64'(out_valid), 64'd0);
        check64("reset_out_p", out_p, 64'd0);
        check64("reset_out_approx", 64'(out_approx), 64'd0);
        check64("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Latency: result appears in the third cycle after the accepting edge.
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        @(negedge clk);
        check64("latency_c1", 64'(out_valid), 64'd0);
        @(negedge clk);
        check64("latency_c2", 64'(out_valid), 64'd0);
        @(negedge clk);
        check64("latency_c3", 64'(out_valid), 64'd1);
        drain();

        for (int i = 0; i < 10; i++) send(tbl[i].a, tbl[i].b, tbl[i].ap, tbl[i].p);
        drain();

        // Streaming: four results on consecutive cycles.
        run    = 0;
        maxrun = 0;
        send(32'h1,       32'h2,     1'b0, 64'h2);
        send(32'h3,       32'h4,     1'b0, 64'hC);
        send(32'hFFFF,    32'hFFFF,  1'b0, 64'hFFFE_0001);
        send(32'h1_0000,  32'h3,     1'b0, 64'h3_0000);
        drain();
        check64("stream_run", 64'(maxrun), 64'd4);

        // Backpressure: three beats in flight, output stalled for five cycles.
        out_ready = 1'b0;
        send(32'h0000_0007, 32'h0000_0009, 1'b0, 64'd63);
        send(32'h0000_1234, 32'h0000_0100, 1'b1, 64'h0000_0000_0012_0000);
        send(32'h0001_0001, 32'h0001_0001, 1'b0, 64'h0000_0001_0002_0001);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check64("bp_in_ready", 64'(in_ready), 64'd0);
            check64("bp_out_p", out_p, 64'd63);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // Reset mid-flight, with a beat presented during reset that must be ignored.
        send(32'h0000_0005, 32'h0000_0005, 1'b0, 64'd25);
        send(32'h0000_0006, 32'h0000_0006, 1'b0, 64'd36);
        rst      = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check64("rst_mid_out_valid", 64'(out_valid), 64'd0);
        check64("rst_mid_in_ready", 64'(in_ready), 64'd1);
`ifdef KARATSUBA_PERF_CNT_EN
        check64("rst_mid_perf_total", 64'(perf_total), 64'd0);
`endif
        repeat (6) @(posedge clk);
        #1;

        // Random traffic with random output backpressure, checked against the plain-product model.
        rand_bp = 1'b1;
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a, b;
            logic        ap;
            a  = $urandom;
            b  = $urandom;
            ap = 1'($urandom_range(0, 1));
            if (i % 7 == 3) a = 32'hFFFF_FFFF;
            send(a, b, ap, model(a, b, ap));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        #2;
        rand_bp   = 1'b0;
        out_ready = 1'b1;
        drain();

`ifdef KARATSUBA_PERF_CNT_EN
        check64("perf_total", 64'(perf_total), 64'(n_hs));
        check64("perf_approx", 64'(perf_approx), 64'(n_hs_ap));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
